// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the seg_scan multiplexed display scanner.
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int TIME_W     = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] SEL_OFF = 6'h3F;
  localparam logic [DIGIT_W-1:0]    BCD_MAX = 4'd9;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_IDX = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    HS_READY   = 1'b0,
    HS_PENDING = 1'b1
  } hs_state_t;

  function automatic logic [DIGIT_W-1:0] nibble_at(input logic [TIME_W-1:0] word,
                                                   input digit_idx_t idx);
    case (idx)
      3'd0:    return word[3:0];
      3'd1:    return word[7:4];
      3'd2:    return word[11:8];
      3'd3:    return word[15:12];
      3'd4:    return word[19:16];
      3'd5:    return word[23:20];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Upstream time-word channel into seg_scan.
// A word transfers on a rising edge where time_valid && time_ready; the source holds
// time_bcd stable while time_valid is high and time_ready is low.
interface seg_scan_if;
  import seg_pkg::*;

  logic              time_valid;
  logic [TIME_W-1:0] time_bcd;
  logic              time_ready;

  modport master (output time_valid, output time_bcd, input time_ready);
  modport slave  (input time_valid, input time_bcd, output time_ready);

endinterface

// File: rtl/seg_prescaler.sv
// Slot prescaler: counts 0..CLK_DIV-1 and flags the last cycle of each digit slot.
module seg_prescaler #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_tick  = (r_count == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit time display scanner with a one-deep pending buffer committed at frame boundaries.
// Optional build macro SEG_SCAN_LZ_BLANK_EN blanks the hours-tens digit when it is zero.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_if.slave             tif,
  output logic [DIGIT_W-1:0]    number,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  bcd_err,
  output hs_state_t             o_dbg_hs_state
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic              w_tick;
  logic [CNT_W-1:0]  w_count;
  logic              w_boundary;
  logic              w_take;
  logic              w_commit;
  digit_idx_t        r_idx;
  digit_idx_t        w_idx_nxt;
  logic [TIME_W-1:0] r_disp;
  logic [TIME_W-1:0] r_pend;
  logic [TIME_W-1:0] w_disp_nxt;
  logic [DIGIT_W-1:0] w_nib;
  hs_state_t         r_state;
  hs_state_t         w_state_nxt;

  seg_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .o_tick  (w_tick),
    .o_count (w_count)
  );

  assign w_boundary     = w_tick && (r_idx == LAST_IDX);
  assign w_idx_nxt      = (r_idx == LAST_IDX) ? '0 : r_idx + 3'd1;
  assign tif.time_ready = (r_state == HS_READY);
  assign o_dbg_hs_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HS_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready depends only on registered state, so time_valid never reaches time_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      HS_READY: begin
        if (tif.time_valid) begin
          w_take      = 1'b1;
          w_state_nxt = HS_PENDING;
        end
      end
      HS_PENDING: begin
        if (w_boundary) begin
          w_commit    = 1'b1;
          w_state_nxt = HS_READY;
        end
      end
      default: w_state_nxt = HS_READY;
    endcase
  end

  // The first digit of a new frame must come from the word being committed on this edge.
  assign w_disp_nxt = w_commit ? r_pend : r_disp;
  assign w_nib      = nibble_at(w_disp_nxt, w_idx_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_disp  <= '0;
      r_pend  <= '0;
      number  <= '0;
      bcd_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_pend <= tif.time_bcd;
      end
      if (w_commit) begin
        r_disp <= r_pend;
      end
      if (w_tick) begin
        r_idx  <= w_idx_nxt;
        number <= (w_nib > BCD_MAX) ? '0 : w_nib;
        if (w_nib > BCD_MAX) begin
          bcd_err <= 1'b1;
        end
      end
    end
  end

  // Blank window at slot start lets the registered decoder settle before any digit lights.
  always_comb begin
    digit_sel = SEL_OFF;
    if (w_count >= CNT_W'(BLANK_CYC)) begin
      digit_sel = SEL_OFF & ~(NUM_DIGITS'(1) << r_idx);
    end
`ifdef SEG_SCAN_LZ_BLANK_EN
    if ((r_idx == LAST_IDX) && (r_disp[TIME_W-1 -: DIGIT_W] == '0)) begin
      digit_sel = SEL_OFF;
    end
`endif
  end

endmodule
